rca_issue_sequencer: RTL and testbench
======================================

Name: rca_issue_sequencer

Overview:
- Issue-side sequencer for the reconfigurable custom accelerator (RCA) grid; successor to the single-slot grid issue controller.
- Registers each RCA-use request for one cycle, then forwards it to the grid.
- Tracks in-flight instruction IDs in order for writeback and bounds their number.
- On an accelerator switch, drains the grid and then holds a multi-cycle IO-FIFO clear before issuing to the new RCA.

Parameters:
- NUM_RCAS, 3, number of accelerators; SEL_W = max(1, $clog2(NUM_RCAS)).
- NUM_READ_PORTS, 5, register-source operands per instruction.
- XLEN, 32, operand width.
- ID_W, 3, instruction ID width.
- MAX_INFLIGHT, 8, maximum outstanding grid instructions. Must be ≤ 2**ID_W.
- CLEAR_CYCLES, 2, cycles clear_fifos is held on a switch. Must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- issue_valid  in  1  new request this cycle
- issue_ready  out  1  request may be accepted
- issue_id  in  ID_W  instruction ID
- issue_rca_sel  in  SEL_W  target RCA
- issue_use_instr  in  1  request is an RCA-use instruction
- issue_fb_instr  in  1  feedback-use variant (operands are read)
- issue_rs_data  in  NUM_READ_PORTS*XLEN  operands, rs1 in the low XLEN bits
- grid_valid  out  1  one-cycle issue pulse to the grid / ID push
- grid_id  out  ID_W  buffered ID
- grid_rca_sel  out  SEL_W  buffered selection
- grid_rs_valid  out  1  equals grid_valid && buffered fb flag
- grid_rs_data  out  NUM_READ_PORTS*XLEN  buffered operands
- clear_fifos  out  1  clear IO-unit FIFOs and load/store counters
- active_rca  out  SEL_W  RCA currently owning the grid
- active_valid  out  1  active_rca is meaningful
- wb_commit  in  1  oldest in-flight instruction retires this cycle
- wb_id  out  ID_W  ID of the oldest in-flight instruction
- wb_fb  out  1  fb flag of the oldest in-flight instruction
- inflight_count  out  $clog2(MAX_INFLIGHT+1)  outstanding instructions
- busy  out  1  state != ACCEPT or buffer valid or inflight_count != 0

Behaviour:
- Reset values (async): state ACCEPT; buffer empty; FIFO empty; counter 0; active_valid 0; active_rca 0; every pulse output 0.
- Accept handshake: accept = issue_valid && issue_ready.
- issue_ready = (state == ACCEPT) && (inflight_count + buf_valid < MAX_INFLIGHT).
- On accept, the request is captured in a one-deep buffer.
- A request with use_instr=0 is consumed and dropped: no grid_valid, no state change.
- Switch check on accept, use_instr=1:
  - needs_switch = !active_valid || (sel != active_rca).
  - !needs_switch: grid_valid at accept+1. A new request may be accepted in that same cycle, so back-to-back issue runs at 1/cycle.
  - needs_switch && inflight_count == 0 && !buf_valid: go to CLEAR.
  - needs_switch otherwise: go to DRAIN.
- DRAIN: issue_ready=0. Move to CLEAR in the cycle after inflight_count reaches 0.
- CLEAR: clear_fifos=1 for exactly CLEAR_CYCLES cycles.
  - On the last clear cycle, set active_rca := buffered sel and active_valid := 1.
  - grid_valid is pulsed in the next cycle and state returns to ACCEPT.
  - clear_fifos and grid_valid never coincide.
- Same-RCA issue never asserts clear_fifos, even when the grid is idle. This differs from the previous generation.
- ID FIFO, depth MAX_INFLIGHT, in-order:
  - Push on grid_valid with {id, fb}; pop on wb_commit.
  - wb_id and wb_fb show the head entry; they are 0 when empty.
- inflight_count: +1 on grid_valid, -1 on wb_commit; a simultaneous push and pop leaves it unchanged.
- wb_commit while empty is ignored (count saturates at 0) and fires a simulation assertion.
- Push when full cannot occur because of the ready gating; assert it.
- FIFO pointers wrap modulo MAX_INFLIGHT, which need not be a power of 2.
- Reset mid-DRAIN or mid-CLEAR: everything returns to reset values; the buffered request is lost. Upstream flushes on reset.

Decomposition:
- Shared package rca_config: NUM_RCAS, NUM_READ_PORTS, MAX_INFLIGHT, CLEAR_CYCLES defaults, the SEL_W function, and typedef enum {ACCEPT, DRAIN, CLEAR} rca_seq_state_t.
- One sub-module: rca_id_fifo. Parametrised depth and width, async-reset, with push/pop/head/count/full/empty.

Test Plan:
- Reset, then accept id=1 sel=0 → clear_fifos for 2 cycles; active_rca=0, active_valid=1; grid_valid 1 cycle after the clear window with grid_id=1.
- 4 back-to-back sel=0 requests, ids 2–5 → grid_valid 4 consecutive cycles, no clear_fifos; inflight_count=4; wb_id=2, then 3, 4, 5 as wb_commit pulses.
- 2 instructions in flight on sel=0, accept sel=1 id=6 → DRAIN with issue_ready=0. After 2 commits: 2 clear cycles, then grid_valid with grid_rca_sel=1, active_rca=1.
- Fill to MAX_INFLIGHT=8 → issue_ready=0. A single wb_commit → ready returns the next cycle.
- Simultaneous grid_valid and wb_commit → inflight_count unchanged. Feedback request with fb=1 → grid_rs_valid=1, grid_rs_data matches the operands; wb_fb=1 at the head.
- Assert rst during CLEAR cycle 1 → clear_fifos=0 immediately (async); state ACCEPT; active_valid=0; count 0.

Source files
------------

// File: rtl/rca_config.sv
// Shared configuration for the RCA issue sequencer: default sizes, the
// sequencer state type and the select-width helper.
package rca_config;

    localparam int DEF_NUM_RCAS       = 3;
    localparam int DEF_NUM_READ_PORTS = 5;
    localparam int DEF_XLEN           = 32;
    localparam int DEF_ID_W           = 3;
    localparam int DEF_MAX_INFLIGHT   = 8;
    localparam int DEF_CLEAR_CYCLES   = 2;

    typedef enum logic [1:0] {
        ACCEPT,
        DRAIN,
        CLEAR
    } rca_seq_state_t;

    // max(1, clog2(n)); also used for pointer and small counter widths
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_id_fifo.sv
// In-order FIFO of in-flight instruction tags. The head is visible
// combinationally and reads as zero when empty. Depth need not be a power of 2.
module rca_id_fifo
    import rca_config::*;
#(
    parameter int DEPTH = DEF_MAX_INFLIGHT,
    parameter int WIDTH = DEF_ID_W + 1,
    localparam int PTR_W = sel_width(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rca_issue_sequencer.sv
// Issue-side sequencer for the RCA grid: one-deep request buffer, in-order
// in-flight ID tracking, and drain + FIFO-clear sequencing on an RCA switch.
module rca_issue_sequencer
    import rca_config::*;
#(
    parameter int NUM_RCAS       = DEF_NUM_RCAS,
    parameter int NUM_READ_PORTS = DEF_NUM_READ_PORTS,
    parameter int XLEN           = DEF_XLEN,
    parameter int ID_W           = DEF_ID_W,
    parameter int MAX_INFLIGHT   = DEF_MAX_INFLIGHT,
    parameter int CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
    localparam int SEL_W = sel_width(NUM_RCAS),
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1),
    localparam int DW    = NUM_READ_PORTS * XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [ID_W-1:0]  issue_id,
    input  logic [SEL_W-1:0] issue_rca_sel,
    input  logic             issue_use_instr,
    input  logic             issue_fb_instr,
    input  logic [DW-1:0]    issue_rs_data,
    output logic             grid_valid,
    output logic [ID_W-1:0]  grid_id,
    output logic [SEL_W-1:0] grid_rca_sel,
    output logic             grid_rs_valid,
    output logic [DW-1:0]    grid_rs_data,
    output logic             clear_fifos,
    output logic [SEL_W-1:0] active_rca,
    output logic             active_valid,
    input  logic             wb_commit,
    output logic [ID_W-1:0]  wb_id,
    output logic             wb_fb,
    output logic [CNT_W-1:0] inflight_count,
    output logic             busy
);

    localparam int CLR_W = sel_width(CLEAR_CYCLES);

    if (CLEAR_CYCLES < 1) begin : g_bad_clear
        $error("CLEAR_CYCLES must be at least 1");
    end
    if (MAX_INFLIGHT > (1 << ID_W)) begin : g_bad_depth
        $error("MAX_INFLIGHT must not exceed 2**ID_W");
    end

    rca_seq_state_t   state_q, state_d;
    logic             buf_valid_q, buf_valid_d;
    logic [ID_W-1:0]  buf_id_q, buf_id_d;
    logic [SEL_W-1:0] buf_sel_q, buf_sel_d;
    logic             buf_fb_q, buf_fb_d;
    logic [DW-1:0]    buf_data_q, buf_data_d;
    logic [SEL_W-1:0] active_rca_q, active_rca_d;
    logic             active_valid_q, active_valid_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic             accept, needs_switch, room;
    logic [ID_W:0]    fifo_head;
    logic             fifo_full, fifo_empty;

    // A buffered request counts against the in-flight bound so a push can never overflow
    assign room         = (int'(inflight_count) + int'(buf_valid_q)) < MAX_INFLIGHT;
    assign issue_ready  = (state_q == ACCEPT) && room;
    assign accept       = issue_valid && issue_ready;
    assign needs_switch = !active_valid_q || (issue_rca_sel != active_rca_q);

    // Buffered requests only sit in ACCEPT once they own the grid
    assign grid_valid    = (state_q == ACCEPT) && buf_valid_q;
    assign grid_id       = buf_id_q;
    assign grid_rca_sel  = buf_sel_q;
    assign grid_rs_valid = grid_valid && buf_fb_q;
    assign grid_rs_data  = buf_data_q;
    assign clear_fifos   = (state_q == CLEAR);
    assign active_rca    = active_rca_q;
    assign active_valid  = active_valid_q;
    assign wb_id         = fifo_head[ID_W:1];
    assign wb_fb         = fifo_head[0];
    assign busy          = (state_q != ACCEPT) || buf_valid_q || (inflight_count != '0);

    always_comb begin
        state_d        = state_q;
        buf_valid_d    = buf_valid_q;
        buf_id_d       = buf_id_q;
        buf_sel_d      = buf_sel_q;
        buf_fb_d       = buf_fb_q;
        buf_data_d     = buf_data_q;
        active_rca_d   = active_rca_q;
        active_valid_d = active_valid_q;
        clr_cnt_d      = clr_cnt_q;

        unique case (state_q)
            ACCEPT: begin
                if (grid_valid) begin
                    buf_valid_d = 1'b0;
                end
                if (accept && issue_use_instr) begin
                    buf_valid_d = 1'b1;
                    buf_id_d    = issue_id;
                    buf_sel_d   = issue_rca_sel;
                    buf_fb_d    = issue_fb_instr;
                    buf_data_d  = issue_rs_data;
                    if (needs_switch) begin
                        state_d = ((inflight_count == '0) && !buf_valid_q) ? CLEAR : DRAIN;
                    end
                end
            end
            DRAIN: begin
                clr_cnt_d = '0;
                if (inflight_count == '0) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    clr_cnt_d      = '0;
                    state_d        = ACCEPT;
                    active_rca_d   = buf_sel_q;
                    active_valid_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ACCEPT;
            buf_valid_q    <= 1'b0;
            buf_id_q       <= '0;
            buf_sel_q      <= '0;
            buf_fb_q       <= 1'b0;
            buf_data_q     <= '0;
            active_rca_q   <= '0;
            active_valid_q <= 1'b0;
            clr_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            buf_valid_q    <= buf_valid_d;
            buf_id_q       <= buf_id_d;
            buf_sel_q      <= buf_sel_d;
            buf_fb_q       <= buf_fb_d;
            buf_data_q     <= buf_data_d;
            active_rca_q   <= active_rca_d;
            active_valid_q <= active_valid_d;
            clr_cnt_q      <= clr_cnt_d;
        end
    end

    rca_id_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (ID_W + 1)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grid_valid),
        .push_data ({buf_id_q, buf_fb_q}),
        .pop       (wb_commit),
        .head      (fifo_head),
        .count     (inflight_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(wb_commit && fifo_empty)) else $error("wb_commit with no instruction in flight");
            assert (!(grid_valid && fifo_full)) else $error("grid issue into a full ID FIFO");
        end
    end

endmodule

// File: tb/tb_rca_issue_sequencer.sv
// Directed walk through the issue/drain/clear scenarios, then a randomized
// phase scored against a transaction-level model of issue order and writeback.
module tb_rca_issue_sequencer;

    localparam int NUM_RCAS = 3;
    localparam int NRP      = 5;
    localparam int XLEN     = 32;
    localparam int ID_W     = 3;
    localparam int MAXI     = 8;
    localparam int CLRC     = 2;
    localparam int SEL_W    = 2;
    localparam int CNT_W    = 4;
    localparam int DW       = NRP * XLEN;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid, issue_ready;
    logic [ID_W-1:0]  issue_id;
    logic [SEL_W-1:0] issue_rca_sel;
    logic             issue_use_instr, issue_fb_instr;
    logic [DW-1:0]    issue_rs_data;
    logic             grid_valid, grid_rs_valid, clear_fifos, active_valid;
    logic [ID_W-1:0]  grid_id, wb_id;
    logic [SEL_W-1:0] grid_rca_sel, active_rca;
    logic [DW-1:0]    grid_rs_data;
    logic             wb_commit, wb_fb, busy;
    logic [CNT_W-1:0] inflight_count;

    rca_issue_sequencer #(
        .NUM_RCAS(NUM_RCAS), .NUM_READ_PORTS(NRP), .XLEN(XLEN), .ID_W(ID_W),
        .MAX_INFLIGHT(MAXI), .CLEAR_CYCLES(CLRC)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_id(issue_id),
        .issue_rca_sel(issue_rca_sel), .issue_use_instr(issue_use_instr),
        .issue_fb_instr(issue_fb_instr), .issue_rs_data(issue_rs_data),
        .grid_valid(grid_valid), .grid_id(grid_id), .grid_rca_sel(grid_rca_sel),
        .grid_rs_valid(grid_rs_valid), .grid_rs_data(grid_rs_data),
        .clear_fifos(clear_fifos), .active_rca(active_rca), .active_valid(active_valid),
        .wb_commit(wb_commit), .wb_id(wb_id), .wb_fb(wb_fb),
        .inflight_count(inflight_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        int            sel;
        bit            fb;
        logic [DW-1:0] data;
        bit            need_clear;
    } req_t;

    typedef struct {
        int id;
        bit fb;
    } wb_t;

    req_t exp_q[$];
    wb_t  wb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < NRP; i++) d[i*XLEN +: XLEN] = $urandom;
        return d;
    endfunction

    task automatic set_req(input bit v, input int id, input int sel, input bit use_i,
                           input bit fb, input logic [DW-1:0] d);
        issue_valid     = v;
        issue_id        = ID_W'(id);
        issue_rca_sel   = SEL_W'(sel);
        issue_use_instr = use_i;
        issue_fb_instr  = fb;
        issue_rs_data   = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n, last_sel, cur_sel, clear_run;
        bit            v, use_b, fb_b, commit;
        logic [DW-1:0] fbdata;
        req_t          r;
        wb_t           w;

        rst = 1'b1;
        wb_commit = 1'b0;
        set_req(0, 0, 0, 0, 0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        settle();
        chk("reset_ready", issue_ready, 1);
        chk("reset_grid_valid", grid_valid, 0);
        chk("reset_clear", clear_fifos, 0);
        chk("reset_active_valid", active_valid, 0);
        chk("reset_count", inflight_count, 0);
        chk("reset_busy", busy, 0);

        // First request on an idle grid: clear window, then issue
        set_req(1, 1, 0, 1, 0, rnd_data());
        settle();
        tick();
        issue_valid = 0;
        settle();
        chk("first_clear_c1", clear_fifos, 1);
        chk("first_grid_c1", grid_valid, 0);
        chk("first_ready_c1", issue_ready, 0);
        tick(); settle();
        chk("first_clear_c2", clear_fifos, 1);
        tick(); settle();
        chk("first_clear_end", clear_fifos, 0);
        chk("first_grid", grid_valid, 1);
        chk("first_grid_id", grid_id, 1);
        chk("first_active_rca", active_rca, 0);
        chk("first_active_valid", active_valid, 1);
        tick();
        wb_commit = 1; settle();
        chk("first_count", inflight_count, 1);
        chk("first_wb_id", wb_id, 1);
        tick();
        wb_commit = 0;

        // Back-to-back same-RCA issue
        for (int k = 0; k < 4; k++) begin
            set_req(1, 2 + k, 0, 1, 0, rnd_data());
            settle();
            chk("b2b_ready", issue_ready, 1);
            if (k > 0) begin
                chk("b2b_grid", grid_valid, 1);
                chk("b2b_grid_id", grid_id, 1 + k);
            end
            chk("b2b_no_clear", clear_fifos, 0);
            tick();
        end
        issue_valid = 0; settle();
        chk("b2b_last_grid", grid_valid, 1);
        chk("b2b_last_id", grid_id, 5);
        chk("b2b_last_no_clear", clear_fifos, 0);
        tick(); settle();
        chk("b2b_count", inflight_count, 4);
        chk("b2b_idle", grid_valid, 0);
        for (int k = 0; k < 2; k++) begin
            wb_commit = 1; settle();
            chk("b2b_wb_id", wb_id, 2 + k);
            tick();
        end
        wb_commit = 0;

        // Switch to RCA 1 with two in flight: drain, clear, issue
        set_req(1, 6, 1, 1, 0, rnd_data());
        settle();
        chk("sw_ready", issue_ready, 1);
        chk("sw_count", inflight_count, 2);
        tick();
        issue_valid = 0; settle();
        chk("drain_ready", issue_ready, 0);
        chk("drain_no_clear", clear_fifos, 0);
        chk("drain_busy", busy, 1);
        tick(); settle();
        chk("drain_hold", issue_ready, 0);
        for (int k = 0; k < 2; k++) begin
            wb_commit = 1; settle();
            chk("drain_wb_id", wb_id, 4 + k);
            chk("drain_no_grid", grid_valid, 0);
            tick();
        end
        wb_commit = 0; settle();
        n = 0;
        while (clear_fifos !== 1'b1 && n < 5) begin
            chk("drain_wait_ready", issue_ready, 0);
            tick(); settle();
            n++;
        end
        chk("sw_clear_c1", clear_fifos, 1);
        chk("sw_clear_count", inflight_count, 0);
        tick(); settle();
        chk("sw_clear_c2", clear_fifos, 1);
        tick(); settle();
        chk("sw_clear_end", clear_fifos, 0);
        chk("sw_grid", grid_valid, 1);
        chk("sw_grid_sel", grid_rca_sel, 1);
        chk("sw_grid_id", grid_id, 6);
        chk("sw_active_rca", active_rca, 1);
        tick();
        wb_commit = 1; settle();
        chk("sw_wb_id", wb_id, 6);
        tick();
        wb_commit = 0;

        // Fill to the in-flight limit
        for (int k = 0; k < 8; k++) begin
            set_req(1, k, 1, 1, 0, rnd_data());
            settle();
            chk("fill_ready", issue_ready, 1);
            tick();
        end
        issue_valid = 0; settle();
        chk("full_ready_buf", issue_ready, 0);
        tick(); settle();
        chk("full_count", inflight_count, 8);
        chk("full_ready", issue_ready, 0);
        wb_commit = 1; settle();
        chk("full_wb_id", wb_id, 0);
        tick();
        wb_commit = 0; settle();
        chk("ready_back", issue_ready, 1);
        chk("ready_back_count", inflight_count, 7);

        // Feedback request issued in the same cycle as a commit
        fbdata = rnd_data();
        set_req(1, 2, 1, 1, 1, fbdata);
        settle();
        chk("fb_ready", issue_ready, 1);
        tick();
        issue_valid = 0; wb_commit = 1; settle();
        chk("fb_grid", grid_valid, 1);
        chk("fb_rs_valid", grid_rs_valid, 1);
        chk("fb_rs_data", grid_rs_data, fbdata);
        chk("fb_wb_id", wb_id, 1);
        tick();
        wb_commit = 0; settle();
        chk("push_pop_same", inflight_count, 7);
        chk("fb_rs_valid_low", grid_rs_valid, 0);
        for (int k = 0; k < 7; k++) begin
            wb_commit = 1; settle();
            chk("fb_drain_id", wb_id, (k < 6) ? 2 + k : 2);
            chk("fb_drain_fb", wb_fb, (k == 6) ? 1 : 0);
            tick();
        end
        wb_commit = 0; settle();
        chk("empty_count", inflight_count, 0);
        chk("empty_wb_id", wb_id, 0);

        // Non-use request is dropped
        set_req(1, 5, 2, 0, 0, rnd_data());
        settle();
        tick();
        issue_valid = 0; settle();
        chk("drop_grid", grid_valid, 0);
        chk("drop_clear", clear_fifos, 0);
        chk("drop_busy", busy, 0);

        // Reset in the middle of a clear window
        set_req(1, 1, 0, 1, 0, rnd_data());
        settle();
        tick();
        issue_valid = 0; settle();
        chk("rst_pre_clear", clear_fifos, 1);
        rst = 1; #1;
        chk("rst_async_clear", clear_fifos, 0);
        chk("rst_active_valid", active_valid, 0);
        chk("rst_count", inflight_count, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst = 0; settle();
        chk("rst_ready", issue_ready, 1);
        tick(); settle();
        chk("rst_no_grid", grid_valid, 0);

        // Randomized phase against the transaction-level model
        last_sel = -1;
        cur_sel = 0;
        clear_run = 0;
        for (int cyc = 0; cyc < 650; cyc++) begin
            if ($urandom_range(0, 4) == 0) cur_sel = $urandom_range(0, NUM_RCAS - 1);
            v = (cyc < 500) && ($urandom_range(0, 1) == 1);
            use_b = ($urandom_range(0, 9) != 0);
            fb_b = $urandom_range(0, 1);
            commit = (wb_q.size() > 0) && ($urandom_range(0, 99) < ((cyc < 500) ? 35 : 70));
            set_req(v, $urandom_range(0, 7), cur_sel, use_b, fb_b, rnd_data());
            wb_commit = commit;
            settle();
            chk("rnd_count", inflight_count, wb_q.size());
            if (clear_fifos === 1'b1) begin
                clear_run++;
                chk("rnd_clear_excl", grid_valid, 0);
            end
            if (commit) begin
                w = wb_q.pop_front();
                chk("rnd_wb_id", wb_id, w.id);
                chk("rnd_wb_fb", wb_fb, w.fb);
            end
            if (grid_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious_grid", grid_valid, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("rnd_grid_id", grid_id, r.id);
                    chk("rnd_grid_sel", grid_rca_sel, r.sel);
                    chk("rnd_rs_valid", grid_rs_valid, r.fb);
                    chk("rnd_rs_data", grid_rs_data, r.data);
                    chk("rnd_active", active_rca, r.sel);
                    chk("rnd_clear_len", clear_run, r.need_clear ? CLRC : 0);
                    w.id = r.id;
                    w.fb = r.fb;
                    wb_q.push_back(w);
                end
                clear_run = 0;
            end
            if (issue_valid && issue_ready && issue_use_instr) begin
                r.id = int'(issue_id);
                r.sel = cur_sel;
                r.fb = fb_b;
                r.data = issue_rs_data;
                r.need_clear = (last_sel != cur_sel);
                last_sel = cur_sel;
                exp_q.push_back(r);
            end
            tick();
        end
        issue_valid = 0;
        wb_commit = 0;
        chk("rnd_all_issued", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
